hilo_muldiv_ctrl: RTL and testbench

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

---
 rtl/hilo_muldiv_ctrl.sv | 134 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: 1-bit-per-cycle shift-add multiply and restoring divide.
// It takes 32 RUN cycles plus one sign-fix cycle, then pulses DoneE for one cycle.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [4:0]  ALUControlE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        BusyE,
  output logic        DoneE,
  output logic        DivZeroE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic        is_div, neg_res, neg_rem;
  logic [31:0] op_a, acc_hi, acc_lo;

  logic        valid_op, is_div_op, is_signed_op, launch, div_zero;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, rem_shift;
  logic        rem_ge;
  logic [31:0] rem_diff;
  logic [63:0] prod, prod_neg;

  always_comb begin
    valid_op     = (ALUControlE == OP_MULT) || (ALUControlE == OP_MULTU) ||
                   (ALUControlE == OP_DIV)  || (ALUControlE == OP_DIVU);
    is_div_op    = (ALUControlE == OP_DIV) || (ALUControlE == OP_DIVU);
    is_signed_op = (ALUControlE == OP_MULT) || (ALUControlE == OP_DIV);
    launch       = StartE && valid_op && ((state == IDLE) || (state == DONE));
    div_zero     = launch && is_div_op && (SrcBE == 32'd0);
    abs_a        = (is_signed_op && SrcAE[31]) ? (~SrcAE + 32'd1) : SrcAE;
    abs_b        = (is_signed_op && SrcBE[31]) ? (~SrcBE + 32'd1) : SrcBE;
  end

  // Multiply keeps the multiplier in acc_lo; divide keeps the dividend (then quotient) in acc_lo.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : 33'd0);
    rem_shift = {acc_hi, acc_lo[31]};
    rem_ge    = rem_shift >= {1'b0, op_a};
    rem_diff  = rem_shift[31:0] - op_a;
    prod      = {acc_hi, acc_lo};
    prod_neg  = ~prod + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    BusyE      = 1'b0;
    DoneE      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_next = div_zero ? DONE : RUN;
      end
      RUN: begin
        BusyE = 1'b1;
        if (FlushE)             state_next = IDLE;
        else if (cnt == 5'd31)  state_next = FIX;
      end
      FIX: begin
        BusyE = 1'b1;
        if (FlushE) state_next = IDLE;
        else        state_next = DONE;
      end
      DONE: begin
        DoneE = 1'b1;
        if (launch) state_next = div_zero ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      op_a     <= 32'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      DivZeroE <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else if (launch) begin
      cnt      <= 5'd0;
      is_div   <= is_div_op;
      neg_res  <= is_signed_op && (SrcAE[31] ^ SrcBE[31]);
      neg_rem  <= is_signed_op && is_div_op && SrcAE[31];
      op_a     <= is_div_op ? abs_b : abs_a;
      acc_lo   <= is_div_op ? abs_a : abs_b;
      acc_hi   <= 32'd0;
      DivZeroE <= div_zero;
      if (div_zero) begin
        HI <= SrcAE;
        LO <= 32'hFFFF_FFFF;
      end
    end else if ((state == RUN) && !FlushE) begin
      cnt <= cnt + 5'd1;
      if (is_div) begin
        acc_hi <= rem_ge ? rem_diff : rem_shift[31:0];
        acc_lo <= {acc_lo[30:0], rem_ge};
      end else begin
        acc_hi <= mul_sum[32:1];
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end else if ((state == FIX) && !FlushE) begin
      if (is_div) begin
        LO <= neg_res ? (~acc_lo + 32'd1) : acc_lo;
        HI <= neg_rem ? (~acc_hi + 32'd1) : acc_hi;
      end else begin
        {HI, LO} <= neg_res ? prod_neg : prod;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed vector table, hand-written flush/reset/back-to-back
// sequences, and random operations checked against a plain-arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  localparam logic [4:0] OP_MULT  = 5'b01001;
  localparam logic [4:0] OP_MULTU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  logic        clk = 1'b0;
  logic        reset, StartE, FlushE;
  logic [4:0]  ALUControlE;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE, DivZeroE;
  logic [31:0] HI, LO;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_hi, last_lo;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl dut (
    .clk(clk), .reset(reset), .StartE(StartE), .ALUControlE(ALUControlE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .BusyE(BusyE), .DoneE(DoneE), .DivZeroE(DivZeroE), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width signed/unsigned arithmetic, truncating division.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint     sa, sb, q, r;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      OP_MULT: begin
        q = sa * sb;
        hi = q[63:32];
        lo = q[31:0];
      end
      OP_MULTU: begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end else begin
          up = ua / ub;
          hi = 32'(ua % ub);
          lo = up[31:0];
        end
      end
    endcase
  endfunction

  // Launch one op, follow it to DoneE, check timing and results; optionally return to IDLE.
  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input logic exp_dz, input int exp_lat, input bit go_idle);
    int lat, busy_cycles;
    StartE = 1'b1;
    ALUControlE = op;
    SrcAE = a;
    SrcBE = b;
    step();
    StartE = 1'b0;
    SrcAE = $urandom;
    SrcBE = $urandom;
    check_output("divzero_after_launch", 64'(DivZeroE), 64'(exp_dz));
    lat = 1;
    busy_cycles = 0;
    while (!DoneE && lat < 40) begin
      if (BusyE) busy_cycles++;
      step();
      lat++;
    end
    check_output("done_latency", 64'(lat), 64'(exp_lat));
    check_output("busy_cycles", 64'(busy_cycles), 64'(exp_lat - 1));
    check_output("hi", 64'(HI), 64'(exp_hi));
    check_output("lo", 64'(LO), 64'(exp_lo));
    check_output("divzero", 64'(DivZeroE), 64'(exp_dz));
    last_hi = exp_hi;
    last_lo = exp_lo;
    if (go_idle) begin
      step();
      check_output("done_single_pulse", 64'(DoneE), 64'd0);
      check_output("hi_hold", 64'(HI), 64'(exp_hi));
      check_output("lo_hold", 64'(LO), 64'(exp_lo));
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic [4:0]  ops[4];
    logic [31:0] mh, ml, ra, rb;
    logic        mdz;
    int          busy_seen, done_seen, lat;

    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[4] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 34};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};

    reset = 1'b1;
    StartE = 1'b0;
    FlushE = 1'b0;
    ALUControlE = OP_MULT;
    SrcAE = 32'd0;
    SrcBE = 32'd0;
    step();
    step();
    check_output("reset_busy", 64'(BusyE), 64'd0);
    check_output("reset_done", 64'(DoneE), 64'd0);
    check_output("reset_divzero", 64'(DivZeroE), 64'd0);
    check_output("reset_hi", 64'(HI), 64'd0);
    check_output("reset_lo", 64'(LO), 64'd0);
    reset = 1'b0;
    step();

    // An unrecognised op code with StartE must not launch anything.
    StartE = 1'b1;
    ALUControlE = 5'b00000;
    SrcAE = 32'd5;
    SrcBE = 32'd0;
    step();
    StartE = 1'b0;
    check_output("bad_op_busy", 64'(BusyE), 64'd0);
    check_output("bad_op_done", 64'(DoneE), 64'd0);

    for (int i = 0; i < 8; i++)
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                     vecs[i].dz, vecs[i].lat, 1'b1);

    // Flush at cycle 10 of a MULTU, with an ignored divide-by-zero StartE during RUN.
    StartE = 1'b1;
    ALUControlE = OP_MULTU;
    SrcAE = 32'h1234_5678;
    SrcBE = 32'h9ABC_DEF0;
    step();
    busy_seen = 0;
    for (int c = 1; c < 10; c++) begin
      StartE = (c == 4);
      ALUControlE = (c == 4) ? OP_DIVU : OP_MULTU;
      SrcBE = 32'd0;
      if (BusyE) busy_seen++;
      step();
    end
    StartE = 1'b0;
    check_output("busy_before_flush", 64'(busy_seen), 64'd9);
    check_output("start_in_run_ignored_dz", 64'(DivZeroE), 64'd0);
    FlushE = 1'b1;
    step();
    FlushE = 1'b0;
    check_output("flush_busy", 64'(BusyE), 64'd0);
    check_output("flush_done", 64'(DoneE), 64'd0);
    check_output("flush_hi_hold", 64'(HI), 64'(last_hi));
    check_output("flush_lo_hold", 64'(LO), 64'(last_lo));
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (DoneE || BusyE) done_seen++;
      step();
    end
    check_output("flush_no_done", 64'(done_seen), 64'd0);

    // StartE mid-RUN on a full-length op must not disturb it.
    StartE = 1'b1;
    ALUControlE = OP_MULT;
    SrcAE = 32'hFFFF_FFFD;
    SrcBE = 32'd5;
    step();
    StartE = 1'b0;
    lat = 1;
    while (!DoneE && lat < 40) begin
      StartE = (lat == 5);
      ALUControlE = (lat == 5) ? OP_DIVU : OP_MULT;
      SrcBE = 32'd0;
      step();
      lat++;
    end
    StartE = 1'b0;
    check_output("run_start_latency", 64'(lat), 64'd34);
    check_output("run_start_hi", 64'(HI), 64'hFFFF_FFFF);
    check_output("run_start_lo", 64'(LO), 64'hFFFF_FFF1);
    check_output("run_start_dz", 64'(DivZeroE), 64'd0);
    step();

    // Reset at cycle 20 of a MULT overrides StartE and FlushE.
    StartE = 1'b1;
    ALUControlE = OP_MULT;
    SrcAE = 32'h0000_1234;
    SrcBE = 32'hFFFF_0007;
    step();
    StartE = 1'b0;
    repeat (19) step();
    reset = 1'b1;
    StartE = 1'b1;
    FlushE = 1'b1;
    ALUControlE = OP_MULTU;
    step();
    reset = 1'b0;
    StartE = 1'b0;
    FlushE = 1'b0;
    check_output("midreset_busy", 64'(BusyE), 64'd0);
    check_output("midreset_done", 64'(DoneE), 64'd0);
    check_output("midreset_dz", 64'(DivZeroE), 64'd0);
    check_output("midreset_hi", 64'(HI), 64'd0);
    check_output("midreset_lo", 64'(LO), 64'd0);
    step();
    check_output("midreset_stays_idle", 64'(BusyE), 64'd0);

    // Back-to-back: second launch accepted in the DONE cycle of the first.
    apply_stimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 1'b0);
    apply_stimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    apply_stimulus(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    apply_stimulus(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ALUControlE = ops[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = {28'd0, 4'($urandom)};
        2: rb = {28'hFFFFFFF, 4'($urandom)};
        3: ra = {28'hFFFFFFF, 4'($urandom)};
        default: ;
      endcase
      model(ALUControlE, ra, rb, mh, ml, mdz);
      apply_stimulus(ALUControlE, ra, rb, mh, ml, mdz, mdz ? 1 : 34, 1'($urandom_range(0, 1)));
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
